// File: rtl/multicycle_sequencer_pkg.sv
// Shared MIPS encodings for the multi-cycle sequencer and the downstream decode LUT:
// opcodes, R-type functs, phase codes and ALU operation codes.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ST_ID   = 3'd0,
        ST_IF   = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_PASS = 3'd4
    } alu_op_t;

    // Which optional phases an instruction visits after ID.
    typedef struct packed {
        logic legal;
        logic has_exec;
        logic has_mem;
        logic has_wb;
    } path_t;

endpackage

// File: rtl/multicycle_sequencer_phase_path_decode.sv
// Combinational phase-path map: {opcode, funct, current phase} -> {next phase, last phase, illegal}.
// Stall gating is not applied here; the sequencer decides whether the phase actually advances.
module phase_path_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  state_t     cur_state,
    output state_t     next_state,
    output logic       last_phase,
    output logic       illegal
);

    path_t w_path;

    always_comb begin
        w_path = '{legal: 1'b0, has_exec: 1'b0, has_mem: 1'b0, has_wb: 1'b0};
        case (opcode)
            OP_LW, OP_BEQ, OP_BNE: w_path = '{legal: 1'b1, has_exec: 1'b1, has_mem: 1'b1, has_wb: 1'b1};
            OP_SW, OP_JAL:         w_path = '{legal: 1'b1, has_exec: 1'b1, has_mem: 1'b1, has_wb: 1'b0};
            OP_J:                  w_path = '{legal: 1'b1, has_exec: 1'b0, has_mem: 1'b0, has_wb: 1'b0};
            OP_ADDI, OP_XORI:      w_path = '{legal: 1'b1, has_exec: 1'b1, has_mem: 1'b0, has_wb: 1'b1};
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT: w_path = '{legal: 1'b1, has_exec: 1'b1, has_mem: 1'b0, has_wb: 1'b1};
                    FN_JR:                  w_path = '{legal: 1'b1, has_exec: 1'b1, has_mem: 1'b0, has_wb: 1'b0};
                    default:                w_path = '{legal: 1'b0, has_exec: 1'b0, has_mem: 1'b0, has_wb: 1'b0};
                endcase
            end
            default: w_path = '{legal: 1'b0, has_exec: 1'b0, has_mem: 1'b0, has_wb: 1'b0};
        endcase
    end

    // Each phase steps to the next phase its path uses, or finishes back in IF.
    always_comb begin
        next_state = ST_IF;
        last_phase = 1'b0;
        illegal    = 1'b0;
        case (cur_state)
            ST_IF: next_state = ST_ID;
            ST_ID: begin
                if (!w_path.legal)        illegal    = 1'b1;
                else if (w_path.has_exec) next_state = ST_EXEC;
                else                      last_phase = 1'b1;
            end
            ST_EXEC: begin
                if (w_path.has_mem)      next_state = ST_MEM;
                else if (w_path.has_wb)  next_state = ST_WB;
                else                     last_phase = 1'b1;
            end
            ST_MEM: begin
                if (w_path.has_wb) next_state = ST_WB;
                else               last_phase = 1'b1;
            end
            ST_WB:   last_phase = 1'b1;
            default: next_state = ST_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer: owns the IR, phase register, memory-wait stalls,
// sticky illegal flag and the retired-instruction counter.
module multicycle_sequencer
    import mips_defs::*;
#(
    parameter int         CNT_W          = 16,
    parameter logic [2:0] RESET_PC_STATE = 3'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_wait,
    output logic [2:0]       state,
    output logic [31:0]      instr,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    logic [31:0]      r_ir;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    state_t w_state_next;
    state_t w_dec_next;
    logic   w_last_phase;
    logic   w_dec_illegal;
    logic   w_advance;

    phase_path_decode u_decode (
        .opcode     (r_ir[31:26]),
        .funct      (r_ir[5:0]),
        .cur_state  (r_state),
        .next_state (w_dec_next),
        .last_phase (w_last_phase),
        .illegal    (w_dec_illegal)
    );

    // Only IF and MEM talk to memory, so only they can be stalled.
    always_comb begin
        w_advance = 1'b1;
        case (r_state)
            ST_IF:   w_advance = run & ~mem_wait;
            ST_MEM:  w_advance = ~mem_wait;
            default: w_advance = 1'b1;
        endcase
        w_state_next = w_advance ? w_dec_next : r_state;
        instr_done   = w_advance & w_last_phase;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= state_t'(RESET_PC_STATE);
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IF && w_advance)
                r_ir <= mem_rdata;
            if (w_dec_illegal)
                r_illegal <= 1'b1;
            if (instr_done)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign state   = r_state;
    assign instr   = r_ir;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: phase paths, stalls, illegal flag, reset abort
// and counter wrap (second instance with CNT_W=2 sharing the same stimulus).
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] mem_rdata;
    logic        mem_wait;

    logic [2:0]  state, state2;
    logic [31:0] instr, instr2;
    logic        instr_done, instr_done2;
    logic        illegal, illegal2;
    logic [15:0] retired;
    logic [1:0]  retired2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .state(state), .instr(instr), .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    multicycle_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .state(state2), .instr(instr2), .instr_done(instr_done2), .illegal(illegal2), .retired(retired2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks state and instr_done mid-cycle, after inputs for this cycle have settled.
    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic done);
        #2;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".done"},  32'(instr_done), 32'(done));
    endtask

    // Runs one instruction from IF with no stalls; path packs phases 3 bits each, first in [2:0].
    task automatic run_path(input string tag, input logic [31:0] word, input int len,
                            input logic [14:0] path, input int done_at);
        mem_rdata = word;
        run       = 1'b1;
        mem_wait  = 1'b0;
        for (int i = 0; i < len; i++) begin
            expect_cycle($sformatf("%s[%0d]", tag, i), path[3*i +: 3], (i == done_at));
            tick();
        end
        $display("[TB] %s word=%h state=%0d retired=%0d illegal=%0d", tag, word, state, retired, illegal);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_rdata = 32'h0; mem_wait = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst.state",   32'(state), 32'd1);
        check("rst.instr",   instr, 32'h0);
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.retired", 32'(retired), 32'd0);
        mem_rdata = 32'h8C0A0004;
        tick(); tick();
        check("idle.state", 32'(state), 32'd1);
        check("idle.instr", instr, 32'h0);

        run_path("LW", 32'h8C0A0004, 5, {3'd4, 3'd3, 3'd2, 3'd0, 3'd1}, 4);
        check("LW.instr",   instr, 32'h8C0A0004);
        check("LW.retired", 32'(retired), 32'd1);

        run_path("ADD", 32'h012A4020, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 3);
        check("ADD.retired", 32'(retired), 32'd2);
        run_path("J", 32'h08000010, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1);
        check("J.retired", 32'(retired), 32'd3);
        run_path("JR", 32'h03E00008, 3, {3'd0, 3'd0, 3'd2, 3'd0, 3'd1}, 2);
        check("JR.state",   32'(state), 32'd1);
        check("JR.retired", 32'(retired), 32'd4);

        // SW with three stalled MEM cycles then release
        mem_rdata = 32'hAC0A0008; run = 1'b1; mem_wait = 1'b0;
        expect_cycle("SW.if", 3'd1, 1'b0); tick();
        expect_cycle("SW.id", 3'd0, 1'b0); tick();
        expect_cycle("SW.ex", 3'd2, 1'b0); tick();
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cycle($sformatf("SW.stall%0d", i), 3'd3, 1'b0);
            check("SW.stall.instr", instr, 32'hAC0A0008);
            tick();
        end
        mem_wait = 1'b0;
        expect_cycle("SW.mem", 3'd3, 1'b1);
        tick();
        $display("[TB] SW word=%h state=%0d retired=%0d", 32'hAC0A0008, state, retired);
        check("SW.state",    32'(state), 32'd1);
        check("SW.retired",  32'(retired), 32'd5);
        check("W2.wrap5",    32'(retired2), 32'd1);

        // Fetch stalled by mem_wait: IF held, IR untouched
        mem_rdata = 32'hFFFFFFFF; mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cycle($sformatf("IFwait%0d", i), 3'd1, 1'b0);
            tick();
        end
        check("IFwait.instr", instr, 32'hAC0A0008);
        $display("[TB] IF wait held state=%0d instr=%h", state, instr);

        run_path("ILL", 32'hFC000000, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, -1);
        check("ILL.state",   32'(state), 32'd1);
        check("ILL.illegal", 32'(illegal), 32'd1);
        check("ILL.retired", 32'(retired), 32'd5);

        run_path("ADDI", 32'h20080005, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 3);
        check("ADDI.illegal", 32'(illegal), 32'd1);
        check("ADDI.retired", 32'(retired), 32'd6);
        check("W2.wrap6",     32'(retired2), 32'd2);

        // Reset in the middle of an LW (EXEC phase)
        mem_rdata = 32'h8C0A0004; run = 1'b1; mem_wait = 1'b0;
        tick(); tick();
        check("abort.pre.state", 32'(state), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; run = 1'b0;
        $display("[TB] reset in EXEC state=%0d instr=%h retired=%0d", state, instr, retired);
        check("abort.state",   32'(state), 32'd1);
        check("abort.instr",   instr, 32'h0);
        check("abort.retired", 32'(retired), 32'd0);
        check("abort.illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 5; i++) begin
            expect_cycle($sformatf("halt%0d", i), 3'd1, 1'b0);
            tick();
        end
        check("halt.instr", instr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
